seg7_hex_multi: RTL and testbench

Parametrised, registered hexadecimal display driver for the DE1-SoC seven-segment bank. It captures an unsigned WIDTH-bit value on a load strobe and drives ceil(WIDTH/4) active-low digits. It can optionally suppress leading zeros and blink the whole field. It sits between datapath status registers and the HEX pins and replaces the fixed two-digit combinational decoder.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_hex_multi_if.sv | 37 +++
 rtl/seg7_nibble.sv | 14 +
 rtl/seg7_hex_multi.sv | 135 +++++++++++++
 tb/tb_seg7_hex_multi.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment hex display driver.
// Segment bit 0..6 maps to segments a..g; a 0 bit lights the segment.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_BLANK = 7'b1111111;

    // Glyph table indexed by nibble value 0..F (b and d in lower case).
    localparam seg7_t SEG7_GLYPH [16] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000,   // 9
        7'b0001000,   // A
        7'b0000011,   // b
        7'b1000110,   // C
        7'b0100001,   // d
        7'b0000110,   // E
        7'b0001110    // F
    };

    // Blink phase: ON shows glyphs, OFF blanks every digit.
    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } blink_phase_e;

endpackage

// File: rtl/seg7_hex_multi_if.sv
// Display bus between the datapath and the hex display driver.
// load is a single-cycle strobe with no back-pressure: whenever load is 1 at a
// rising edge the value is captured; there is no ready signal and no hold-off.
// phase exposes the blink state machine for observation.
interface seg7_hex_multi_if #(
    parameter int WIDTH = 8
);
    import seg7_pkg::*;

    localparam int DIGITS = (WIDTH + 3) / 4;

    logic [WIDTH-1:0]   value;
    logic               load;
    logic               lz_blank;
    logic               blink;
    seg7_t [DIGITS-1:0] hex;
    blink_phase_e       phase;

    modport master (
        output value,
        output load,
        output lz_blank,
        output blink,
        input  hex,
        input  phase
    );

    modport slave (
        input  value,
        input  load,
        input  lz_blank,
        input  blink,
        output hex,
        output phase
    );

endinterface

// File: rtl/seg7_nibble.sv
// Combinational nibble to seven-segment glyph decoder.
module seg7_nibble
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output seg7_t      seg
);

    // Direct table lookup of the glyph for this nibble.
    always_comb begin
        seg = SEG7_GLYPH[nib];
    end

endmodule

// File: rtl/seg7_hex_multi.sv
// Registered multi-digit hex display driver with optional leading-zero
// blanking and whole-field blinking.
// Optional feature macro: SEG7_BLINK_EN (blink counter and phase FSM present
// when defined; otherwise the phase is permanently ON and blink is ignored).
module seg7_hex_multi
    import seg7_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    seg7_hex_multi_if.slave  bus
);

    localparam int DIGITS = (WIDTH + 3) / 4;

    logic [WIDTH-1:0]    val_q;
    logic [DIGITS*4-1:0] val_pad;
    seg7_t [DIGITS-1:0]  glyph;
    logic [DIGITS-1:0]   lz_mask;
    logic                zero_run;
    seg7_t [DIGITS-1:0]  hex_d;
    seg7_t [DIGITS-1:0]  hex_q;
    blink_phase_e        phase_q;

    // Capture the displayed value on the load strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= '0;
        end else if (bus.load) begin
            val_q <= bus.value;
        end
    end

    // Zero-pad the value up to a whole number of nibbles.
    always_comb begin
        val_pad             = '0;
        val_pad[WIDTH-1:0]  = val_q;
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            seg7_nibble u_nibble (
                .nib (val_pad[4*g +: 4]),
                .seg (glyph[g])
            );
        end
    endgenerate

    // A digit is a leading zero when it and every higher nibble are zero;
    // digit 0 never qualifies so a zero value still shows "0".
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            zero_run   = zero_run & (val_pad[4*d +: 4] == 4'h0);
            lz_mask[d] = zero_run;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    blink_phase_e  phase_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Blink phase and half-period counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_ON;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    // Phase toggles every BLINK_DIV cycles while blinking; a fresh load
    // restarts a full ON half-period so the new value is seen immediately.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (!bus.blink || bus.load) begin
            phase_d = PH_ON;
            cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            case (phase_q)
                PH_ON:   phase_d = PH_OFF;
                PH_OFF:  phase_d = PH_ON;
                default: phase_d = PH_ON;
            endcase
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end
`else
    logic unused_blink;

    // Without blinking the field is permanently in the ON phase.
    always_comb begin
        phase_q      = PH_ON;
        unused_blink = bus.blink;
    end
`endif

    // Choose glyph or blank per digit from phase and leading-zero mask.
    always_comb begin
        hex_d = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if (phase_q == PH_OFF || (bus.lz_blank && lz_mask[d])) begin
                hex_d[d] = SEG7_BLANK;
            end else begin
                hex_d[d] = glyph[d];
            end
        end
    end

    // Output register driving the pins; reset shows an all-blank field.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q <= '1;
        end else begin
            hex_q <= hex_d;
        end
    end

    assign bus.hex   = hex_q;
    assign bus.phase = phase_q;

endmodule

// File: tb/tb_seg7_hex_multi.sv
// Directed bench for seg7_hex_multi: three instances (WIDTH 8, 12, 5).
// Blink behaviour is exercised when SEG7_BLINK_EN is defined; otherwise the
// bench checks that blink has no effect.
module tb_seg7_hex_multi;
    import seg7_pkg::*;

    localparam logic [6:0] BL = 7'b1111111;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [13:0] blank2;
    logic [13:0] lit_a7;
    logic [13:0] lit_3c;
    logic [13:0] lit_00;

    seg7_hex_multi_if #(.WIDTH(8))  if_a ();
    seg7_hex_multi_if #(.WIDTH(12)) if_b ();
    seg7_hex_multi_if #(.WIDTH(5))  if_c ();

    seg7_hex_multi #(.WIDTH(8), .BLINK_DIV(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    seg7_hex_multi #(.WIDTH(12), .BLINK_DIV(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    seg7_hex_multi #(.WIDTH(5), .BLINK_DIV(4)) dut_c (
        .clk   (clk),
        .reset (reset),
        .bus   (if_c)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyph table written out from the display glyph list.
    function automatic logic [6:0] glyph(input int n);
        case (n)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_a(input logic [7:0] v);
        if_a.value = v;
        if_a.load  = 1'b1;
        tick();
        if_a.load  = 1'b0;
        tick();
    endtask

    task automatic load_b(input logic [11:0] v);
        if_b.value = v;
        if_b.load  = 1'b1;
        tick();
        if_b.load  = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        blank2 = {BL, BL};
        lit_a7 = {7'b0001000, 7'b1111000};
        lit_3c = {7'b0110000, 7'b1000110};
        lit_00 = {7'b1000000, 7'b1000000};

        if_a.value = '0; if_a.load = 1'b0; if_a.lz_blank = 1'b0; if_a.blink = 1'b0;
        if_b.value = '0; if_b.load = 1'b0; if_b.lz_blank = 1'b1; if_b.blink = 1'b0;
        if_c.value = '0; if_c.load = 1'b0; if_c.lz_blank = 1'b0; if_c.blink = 1'b0;

        // Reset state: all digits blank
        reset = 1'b1;
        tick();
        tick();
        chk("rst_a", if_a.hex, blank2);
        chk("rst_b", if_b.hex, {BL, BL, BL});
        chk("rst_c", if_c.hex, blank2);

        // First edge after reset release
        reset = 1'b0;
        tick();
        chk("first_a", if_a.hex, lit_00);
        chk("first_b_lz", if_b.hex, {BL, BL, 7'b1000000});
        chk("first_c", if_c.hex, lit_00);

        // Load 3C: not visible after the capture edge, visible one edge later
        if_a.value = 8'h3C;
        if_a.load  = 1'b1;
        tick();
        if_a.load  = 1'b0;
        chk("lat_a_hold", if_a.hex, lit_00);
        tick();
        chk("load_3c", if_a.hex, lit_3c);

        // Leading-zero blanking on 8 bits
        if_a.lz_blank = 1'b1;
        load_a(8'h05);
        chk("lz_05", if_a.hex, {BL, 7'b0010010});
        load_a(8'h00);
        chk("lz_00", if_a.hex, {BL, 7'b1000000});

        // lz_blank change takes effect one edge later
        if_a.lz_blank = 1'b0;
        tick();
        chk("lz_off", if_a.hex, lit_00);

        // 12-bit leading-zero cases including an internal zero
        load_b(12'h105);
        chk("b_105", if_b.hex, {7'b1111001, 7'b1000000, 7'b0010010});
        load_b(12'h050);
        chk("b_050", if_b.hex, {BL, 7'b0010010, 7'b1000000});
        load_b(12'h000);
        chk("b_000", if_b.hex, {BL, BL, 7'b1000000});
        if_b.lz_blank = 1'b0;
        tick();
        chk("b_000_nolz", if_b.hex, {7'b1000000, 7'b1000000, 7'b1000000});

        // Back-to-back loads on the 8-bit instance
        if_a.value = 8'h11;
        if_a.load  = 1'b1;
        tick();
        if_a.value = 8'h22;
        tick();
        chk("b2b_11", if_a.hex, {glyph(1), glyph(1)});
        if_a.value = 8'h33;
        tick();
        chk("b2b_22", if_a.hex, {glyph(2), glyph(2)});
        if_a.load = 1'b0;
        tick();
        chk("b2b_33", if_a.hex, {glyph(3), glyph(3)});

        // 5-bit sweep with a zero-padded top nibble
        for (int i = 0; i < 32; i++) begin
            if_c.value = 5'(i);
            if_c.load  = 1'b1;
            tick();
            if_c.load  = 1'b0;
            tick();
            chk($sformatf("c_sweep_%0d", i), if_c.hex, {glyph(i / 16), glyph(i % 16)});
        end

`ifdef SEG7_BLINK_EN
        // Blink from a fresh load: 4 lit, 4 blank, 4 lit
        if_a.value = 8'hA7;
        if_a.load  = 1'b1;
        if_a.blink = 1'b1;
        tick();
        if_a.load  = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("blink_%0d", i), if_a.hex, (i <= 4 || i >= 9) ? lit_a7 : blank2);
        end
        tick();
        chk("blink_off_again", if_a.hex, blank2);

        // Load while OFF: new value lit next cycle for a full half-period
        if_a.value = 8'h3C;
        if_a.load  = 1'b1;
        tick();
        if_a.load  = 1'b0;
        chk("reload_edge", if_a.hex, blank2);
        for (int j = 1; j <= 5; j++) begin
            tick();
            chk($sformatf("reload_%0d", j), if_a.hex, (j <= 4) ? lit_3c : blank2);
        end

        // Reset together with load of FF while in OFF
        reset      = 1'b1;
        if_a.value = 8'hFF;
        if_a.load  = 1'b1;
        tick();
        chk("rst_load_blank", if_a.hex, blank2);
        reset     = 1'b0;
        if_a.load = 1'b0;
        tick();
        chk("rst_load_00", if_a.hex, lit_00);
        for (int j = 2; j <= 4; j++) begin
            tick();
            chk($sformatf("post_rst_on_%0d", j), if_a.hex, lit_00);
        end
        tick();
        chk("post_rst_off", if_a.hex, blank2);
        chk("phase_off", if_a.phase, PH_OFF);

        // blink released: steady lit
        if_a.blink = 1'b0;
        tick();
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("steady_%0d", j), if_a.hex, lit_00);
        end
`else
        // blink is ignored: field stays lit
        if_a.blink = 1'b1;
        load_a(8'hA7);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("noblink_%0d", i), if_a.hex, lit_a7);
            tick();
        end

        // Reset together with load of FF
        reset      = 1'b1;
        if_a.value = 8'hFF;
        if_a.load  = 1'b1;
        tick();
        chk("rst_load_blank", if_a.hex, blank2);
        reset     = 1'b0;
        if_a.load = 1'b0;
        tick();
        chk("rst_load_00", if_a.hex, lit_00);
        tick();
        chk("rst_load_00_hold", if_a.hex, lit_00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
